latch_bank_ctrl: RTL and testbench
==================================

Name: latch_bank_ctrl

Overview:
- Write sequencer and two-way arbiter for a bank of external level-sensitive D latches (`d_latch`: d, en, q, qbar), one latch per data bit per entry.
- Takes write requests from two requesters and grants one at a time, round-robin.
- For each write it drives a glitch-free window: data stable with en low (setup), then a one-hot enable pulse, then data held with en low (hold).
- Sits between requester logic and the latch bank. It is the only driver of the latch d/en nets.

Parameters:
- DW, 8, data width (bits per latch entry)
- AW, 2, entry address width; bank has 2**AW entries
- SETUP_CYC, 1, cycles lat_d is stable before lat_en rises (≥1)
- PULSE_CYC, 2, cycles lat_en is high (≥1)
- HOLD_CYC, 1, cycles lat_d is held after lat_en falls (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  write request per requester; held high until ack
- addr0  in  AW  requester 0 entry address
- data0  in  DW  requester 0 write data
- addr1  in  AW  requester 1 entry address
- data1  in  DW  requester 1 write data
- gnt  out  2  one-hot owner of the current write; zero when idle
- ack  out  2  one-cycle completion pulse to the owner
- lat_d  out  DW  data bus to all latch d inputs
- lat_en  out  2**AW  one-hot latch enables
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- One clock; reset is asynchronous and active-low.
- All outputs are registered, and all state changes happen on the rising clk edge.
- Reset (rst_n low, async): state=IDLE, gnt=0, ack=0, lat_d=0, lat_en=0, busy=0, last_gnt=1 (so requester 0 wins the first tie), counter=0.
- Reset mid-write: lat_en drops immediately. The latch keeps whatever was transparent at that instant, which is the stable write data. There is no ack.
- FSM states: IDLE, SETUP, PULSE, HOLD, ACK.
- IDLE:
  - Arbitration happens only here.
  - If exactly one req bit is high, grant it.
  - If both are high, grant the requester opposite last_gnt.
  - On grant: capture the winner's addr/data into internal registers, set gnt one-hot, update last_gnt, load counter, go to SETUP.
  - With no request: stay in IDLE; lat_d holds its last value; lat_en=0.
- SETUP: lat_d = captured data, lat_en=0, for SETUP_CYC cycles, then go to PULSE.
- PULSE: lat_en = one-hot decode of captured addr, for PULSE_CYC cycles, then go to HOLD.
- HOLD: lat_en=0, lat_d unchanged, for HOLD_CYC cycles, then go to ACK.
- ACK:
  - ack[owner]=1 for exactly one cycle; gnt stays asserted in this cycle.
  - Next state is IDLE, with gnt=0 and ack=0.
- Latency: with req sampled at edge t0, lat_en is high during cycles [t0+SETUP_CYC, t0+SETUP_CYC+PULSE_CYC).
  - ack is high in cycle t0+SETUP_CYC+PULSE_CYC+HOLD_CYC. With defaults that is cycle t0+4.
  - Minimum back-to-back spacing is SETUP+PULSE+HOLD+2 cycles (6 with defaults).
- lat_d never changes while any lat_en bit is high, nor in the SETUP_CYC cycles before or HOLD_CYC cycles after.
- lat_en is never multi-hot, including in reset and on state changes.
- Requester inputs are ignored outside IDLE. Changing addr/data after grant has no effect.
- A requester that keeps req high in the IDLE cycle after its ack starts a new write. The round-robin rule still lets a waiting peer win.
- Counter width: enough bits for max(SETUP_CYC, PULSE_CYC, HOLD_CYC). It counts down and advances the state at 1.
- The bank is write-only. Read-back uses the latch q outputs directly.

Test Plan:
- Single write: after reset, req=01, addr0=2, data0=8'hA5 -> gnt=01 next cycle; lat_d=A5; lat_en=0100 for exactly 2 cycles starting 1 cycle after grant; ack=01 4 cycles after sampling; latch[2].q=A5.
- Tie: req=11 from IDLE after reset -> requester 0 served first (ack=01), then requester 1 (ack=10); with both held high, grants alternate 0,1,0,1.
- Stability: random addr/data writes for 200 cycles -> checker confirms lat_d is constant from SETUP start through HOLD end; lat_en is one-hot or zero; no write lasts other than PULSE_CYC cycles.
- Input change after grant: addr0 changes 3→1 and data0 changes 11→22 one cycle after grant -> entry 3 written with 11; entry 1 untouched.
- Reset in PULSE: assert rst_n=0 mid-pulse -> lat_en=0, gnt=0, busy=0 asynchronously with no ack; a write issued after release completes normally with requester 0 winning a tie.
- Parameter sweep: SETUP_CYC=2, PULSE_CYC=1, HOLD_CYC=3 -> ack at t0+6; enable width 1 cycle; busy high for 7 cycles.

Source files
------------

// File: rtl/latch_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : latch_bank_ctrl
//  Purpose  : Write sequencer and two-way round-robin arbiter for a bank of
//             external level-sensitive D latches. Each write drives a
//             setup / one-hot enable pulse / hold window with lat_d frozen
//             throughout, so the latches never see data move while open.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             req[1:0]            - write request per requester (held to ack)
//             addr0/data0         - requester 0 entry address / write data
//             addr1/data1         - requester 1 entry address / write data
//             gnt[1:0]            - one-hot owner of the current write
//             ack[1:0]            - one-cycle completion pulse to the owner
//             lat_d[DW-1:0]       - data bus to every latch d input
//             lat_en[2**AW-1:0]   - one-hot latch enables
//             busy                - high whenever a write is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module latch_bank_ctrl #(
    parameter int DW        = 8,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [AW-1:0]        addr0,
    input  logic [DW-1:0]        data0,
    input  logic [AW-1:0]        addr1,
    input  logic [DW-1:0]        data1,
    output logic [1:0]           gnt,
    output logic [1:0]           ack,
    output logic [DW-1:0]        lat_d,
    output logic [(2**AW)-1:0]   lat_en,
    output logic                 busy
);

    localparam int c_ne      = 2**AW;
    localparam int c_max_sp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int c_max_cyc = (c_max_sp > HOLD_CYC) ? c_max_sp : HOLD_CYC;
    localparam int c_cw      = (c_max_cyc < 2) ? 1 : $clog2(c_max_cyc + 1);

    localparam logic [c_cw-1:0] c_one       = c_cw'(1);
    localparam logic [c_cw-1:0] c_cnt_setup = c_cw'(SETUP_CYC);
    localparam logic [c_cw-1:0] c_cnt_pulse = c_cw'(PULSE_CYC);
    localparam logic [c_cw-1:0] c_cnt_hold  = c_cw'(HOLD_CYC);
    localparam logic [c_ne-1:0] c_en_lsb    = c_ne'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        ACK   = 3'd4
    } state_t;

    state_t            r_state, w_state;
    logic [c_cw-1:0]   r_cnt,   w_cnt;
    logic [1:0]        r_gnt,   w_gnt;
    logic [1:0]        r_ack,   w_ack;
    logic [DW-1:0]     r_lat_d, w_lat_d;
    logic [c_ne-1:0]   r_lat_en, w_lat_en;
    logic              r_busy,  w_busy;
    logic              r_last,  w_last;   // index of the last requester served
    logic [AW-1:0]     r_addr,  w_addr;   // captured entry address

    logic              w_win;             // index of the arbitration winner
    logic [c_ne-1:0]   w_dec;             // one-hot decode of the captured address

    // A lone request wins outright; on a tie the requester not served last wins.
    assign w_win = (req == 2'b11) ? ~r_last : req[1];
    assign w_dec = c_en_lsb << r_addr;

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered and registered, so lat_en comes straight off flops and
    // cannot glitch or go multi-hot on state transitions.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_gnt    = r_gnt;
        w_ack    = 2'b00;
        w_lat_en = '0;
        w_lat_d  = r_lat_d;
        w_last   = r_last;
        w_addr   = r_addr;

        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state = SETUP;
                    w_cnt   = c_cnt_setup;
                    w_gnt   = w_win ? 2'b10 : 2'b01;
                    w_last  = w_win;
                    w_addr  = w_win ? addr1 : addr0;
                    w_lat_d = w_win ? data1 : data0;
                end
            end
            SETUP: begin
                if (r_cnt == c_one) begin
                    w_state  = PULSE;
                    w_cnt    = c_cnt_pulse;
                    w_lat_en = w_dec;
                end else begin
                    w_cnt = r_cnt - c_one;
                end
            end
            PULSE: begin
                if (r_cnt == c_one) begin
                    w_state = HOLD;
                    w_cnt   = c_cnt_hold;
                end else begin
                    w_cnt    = r_cnt - c_one;
                    w_lat_en = w_dec;
                end
            end
            HOLD: begin
                if (r_cnt == c_one) begin
                    w_state = ACK;
                    w_cnt   = '0;
                    w_ack   = r_gnt;
                end else begin
                    w_cnt = r_cnt - c_one;
                end
            end
            ACK: begin
                w_state = IDLE;
                w_gnt   = 2'b00;
            end
            default: begin
                w_state = IDLE;
                w_gnt   = 2'b00;
                w_cnt   = '0;
            end
        endcase

        w_busy = (w_state != IDLE);
    end

    // Reset drops lat_en at once; the open latch keeps the frozen write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_gnt    <= 2'b00;
            r_ack    <= 2'b00;
            r_lat_d  <= '0;
            r_lat_en <= '0;
            r_busy   <= 1'b0;
            r_last   <= 1'b1;
            r_addr   <= '0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_gnt    <= w_gnt;
            r_ack    <= w_ack;
            r_lat_d  <= w_lat_d;
            r_lat_en <= w_lat_en;
            r_busy   <= w_busy;
            r_last   <= w_last;
            r_addr   <= w_addr;
        end
    end

    assign gnt    = r_gnt;
    assign ack    = r_ack;
    assign lat_d  = r_lat_d;
    assign lat_en = r_lat_en;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_latch_bank_ctrl
//  Purpose  : Self-checking bench for latch_bank_ctrl. A transaction-level
//             reference model predicts each write's owner and timing window
//             from the arbitration rule and the cycle arithmetic; a simple
//             latch-bank model captures what the real latches would hold.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_latch_bank_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 2;
    localparam int NE  = 4;
    localparam int S   = 1;
    localparam int P   = 2;
    localparam int H   = 1;
    localparam int LEN = S + P + H;   // ack lands LEN cycles after the grant edge

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      req;
    logic [AW-1:0]   addr0, addr1;
    logic [DW-1:0]   data0, data1;
    logic [1:0]      gnt, ack;
    logic [DW-1:0]   lat_d;
    logic [NE-1:0]   lat_en;
    logic            busy;

    logic [1:0]      sw_req;
    logic [AW-1:0]   sw_addr0, sw_addr1;
    logic [DW-1:0]   sw_data0, sw_data1;
    logic [1:0]      sw_gnt, sw_ack;
    logic [DW-1:0]   sw_lat_d;
    logic [NE-1:0]   sw_lat_en;
    logic            sw_busy;

    latch_bank_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .addr0(addr0), .data0(data0), .addr1(addr1), .data1(data1),
        .gnt(gnt), .ack(ack), .lat_d(lat_d), .lat_en(lat_en), .busy(busy)
    );

    latch_bank_ctrl #(.SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(3)) u_sw (
        .clk(clk), .rst_n(rst_n), .req(sw_req),
        .addr0(sw_addr0), .data0(sw_data0), .addr1(sw_addr1), .data1(sw_data1),
        .gnt(sw_gnt), .ack(sw_ack), .lat_d(sw_lat_d), .lat_en(sw_lat_en), .busy(sw_busy)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_cyc  = 0;
    bit         m_act  = 1'b0;
    int         m_t0   = 0;
    int         m_own  = 0;
    int         m_addr = 0;
    logic [7:0] m_latd = 8'h00;
    int         m_last = 1;

    logic [7:0] bank     [NE];
    logic [7:0] exp_bank [NE];
    int         glog[$];

    bit rnd = 1'b0, keep0 = 1'b0, keep1 = 1'b0, chg = 1'b0;

    function automatic bit m_idle();
        return !m_act || (m_cyc > m_t0 + LEN);
    endfunction

    task automatic model_reset();
        m_act  = 1'b0;
        m_last = 1;
        m_latd = 8'h00;
    endtask

    // Called just after each rising edge with the inputs sampled at it.
    task automatic model_edge();
        int w;
        if (!rst_n) begin
            model_reset();
            m_cyc++;
            return;
        end
        if (m_idle() && req != 2'b00) begin
            if (req == 2'b11) w = (m_last == 1) ? 0 : 1;
            else              w = req[1] ? 1 : 0;
            m_last = w;
            m_own  = w;
            m_t0   = m_cyc + 1;
            m_act  = 1'b1;
            m_addr = w ? int'(addr1) : int'(addr0);
            m_latd = w ? data1 : data0;
        end
        m_cyc++;
    endtask

    task automatic compare();
        logic [1:0]    e_gnt, e_ack;
        logic [NE-1:0] e_en;
        bit            inwin;
        inwin = m_act && (m_cyc >= m_t0) && (m_cyc <= m_t0 + LEN);
        e_gnt = inwin ? 2'(1 << m_own) : 2'b00;
        e_ack = (m_act && m_cyc == m_t0 + LEN) ? 2'(1 << m_own) : 2'b00;
        e_en  = (m_act && m_cyc >= m_t0 + S && m_cyc < m_t0 + S + P) ? NE'(1 << m_addr) : '0;
        for (int i = 0; i < NE; i++) if (lat_en[i]) bank[i] = lat_d;
        if (e_en != '0) exp_bank[m_addr] = m_latd;
        if (inwin && m_cyc == m_t0) glog.push_back(int'(gnt));
        chk("gnt",        32'(gnt),    32'(e_gnt));
        chk("ack",        32'(ack),    32'(e_ack));
        chk("lat_en",     32'(lat_en), 32'(e_en));
        chk("lat_d",      32'(lat_d),  32'(m_latd));
        chk("busy",       32'(busy),   32'(inwin));
        chk("en_onehot0", 32'($onehot0(lat_en)), 32'd1);
    endtask

    // Requester behaviour, applied shortly after each rising edge.
    task automatic drive();
        bit a0, a1;
        a0 = m_act && (m_cyc == m_t0 + LEN) && (m_own == 0);
        a1 = m_act && (m_cyc == m_t0 + LEN) && (m_own == 1);
        if (a0) begin
            if (!keep0) req[0] = 1'b0;
            if (rnd) begin addr0 = AW'($urandom); data0 = DW'($urandom); end
        end
        if (a1) begin
            if (!keep1) req[1] = 1'b0;
            if (rnd) begin addr1 = AW'($urandom); data1 = DW'($urandom); end
        end
        if (chg && m_act && m_cyc == m_t0 && m_own == 0) begin
            addr0 = 2'd1;
            data0 = 8'h22;
            chg   = 1'b0;
        end
        if (rnd) begin
            if (m_act && m_cyc == m_t0) begin
                if (m_own == 0) begin addr0 = AW'($urandom); data0 = DW'($urandom); end
                else            begin addr1 = AW'($urandom); data1 = DW'($urandom); end
            end
            if (!req[0] && $urandom_range(0, 2) == 0) begin
                req[0] = 1'b1; addr0 = AW'($urandom); data0 = DW'($urandom);
            end
            if (!req[1] && $urandom_range(0, 2) == 0) begin
                req[1] = 1'b1; addr1 = AW'($urandom); data1 = DW'($urandom);
            end
            keep0 = 1'($urandom_range(0, 1));
            keep1 = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
        drive();
    endtask

    task automatic wait_quiet(input int budget);
        int i;
        i = 0;
        while (i < budget && !(req == 2'b00 && m_idle())) begin
            step();
            i++;
        end
        chk("quiet_timeout", 32'(req == 2'b00 && m_idle()), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_k, en_k, en_n, busy_n, guard;

        rst_n = 1'b0; req = 2'b00;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        sw_req = 2'b00; sw_addr0 = '0; sw_addr1 = '0; sw_data0 = '0; sw_data1 = '0;
        for (int i = 0; i < NE; i++) begin bank[i] = 8'h00; exp_bank[i] = 8'h00; end
        model_reset();

        // Reset state
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Tie straight after reset: requester 0 first, then alternation
        glog.delete();
        keep0 = 1'b1; keep1 = 1'b1;
        req = 2'b11; addr0 = 2'd0; data0 = 8'h10; addr1 = 2'd1; data1 = 8'h21;
        repeat (4 * (LEN + 2)) step();
        keep0 = 1'b0; keep1 = 1'b0;
        wait_quiet(40);
        for (int i = 0; i < 4; i++)
            chk($sformatf("tie_order%0d", i), 32'(glog.size() > i ? glog[i] : 0),
                (i % 2 == 0) ? 32'd1 : 32'd2);

        // Single write
        req = 2'b01; addr0 = 2'd2; data0 = 8'hA5;
        wait_quiet(20);
        chk("single_bank2", 32'(bank[2]), 32'hA5);

        // Address/data change after grant must not affect the write
        req = 2'b01; addr0 = 2'd3; data0 = 8'h11; chg = 1'b1;
        wait_quiet(20);
        chk("chg_bank3", 32'(bank[3]), 32'h11);
        chk("chg_bank1", 32'(bank[1]), 32'h21);

        // Randomized traffic
        rnd = 1'b1;
        repeat (200) step();
        rnd = 1'b0; keep0 = 1'b0; keep1 = 1'b0;
        wait_quiet(60);
        for (int i = 0; i < NE; i++)
            chk($sformatf("rand_bank%0d", i), 32'(bank[i]), 32'(exp_bank[i]));

        // Reset during the second pulse cycle
        req = 2'b01; addr0 = 2'd2; data0 = 8'h5A;
        guard = 0;
        while (!(m_act && m_cyc == m_t0 + S + 1) && guard < 20) begin
            step();
            guard++;
        end
        chk("rst_reach_pulse", 32'(m_act && m_cyc == m_t0 + S + 1), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_lat_en", 32'(lat_en), 32'd0);
        chk("rst_gnt",    32'(gnt),    32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_ack",    32'(ack),    32'd0);
        req = 2'b00;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        glog.delete();
        req = 2'b11; addr0 = 2'd0; data0 = 8'h77; addr1 = 2'd3; data1 = 8'h88;
        wait_quiet(30);
        chk("rst_tie_first", 32'(glog.size() > 0 ? glog[0] : 0), 32'd1);
        chk("rst_bank2_kept", 32'(bank[2]), 32'h5A);
        chk("rst_bank0",      32'(bank[0]), 32'h77);
        chk("rst_bank3",      32'(bank[3]), 32'h88);

        // Parameter sweep instance: SETUP=2, PULSE=1, HOLD=3
        @(posedge clk);
        #1;
        sw_req = 2'b01; sw_addr0 = 2'd1; sw_data0 = 8'h3C;
        @(posedge clk);
        ack_k = -1; en_k = -1; en_n = 0; busy_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) chk("sw_gnt", 32'(sw_gnt), 32'd1);
            if (sw_busy) busy_n++;
            if (sw_ack != 2'b00) begin
                ack_k = k;
                chk("sw_ack_val", 32'(sw_ack), 32'd1);
            end
            if (sw_lat_en != '0) begin
                en_n++;
                if (en_k < 0) en_k = k;
                chk("sw_en_val", 32'(sw_lat_en), 32'h2);
            end
            if (k == 6) sw_req = 2'b00;
            @(posedge clk);
        end
        chk("sw_ack_cycle", 32'(ack_k),   32'd6);
        chk("sw_en_width",  32'(en_n),    32'd1);
        chk("sw_en_start",  32'(en_k),    32'd2);
        chk("sw_busy_len",  32'(busy_n),  32'd7);
        chk("sw_lat_d",     32'(sw_lat_d), 32'h3C);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
